tcb_arb: RTL
============

TCB_ARB -- requirements
Module: tcb_arb

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width; byte enable width DW/8.
REQ-003 SHALL have parameter PN, default 2, number of manager-side (input) ports, 1..16.
REQ-004 SHALL have parameter MODE, default ARB_RR, arbitration mode (ARB_FIX fixed priority, ARB_RR round-robin).
REQ-005 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port s[PN-1:0], tcb_if.sub array, AW/DW, subordinate ports where managers connect.
REQ-008 SHALL have port m, tcb_if.man, AW/DW, single manager port where the shared subordinate connects.

Function
REQ-009 SHALL set request vector req[i] = s[i].vld.
REQ-010 Grant gnt SHALL be one-hot or zero; SHALL be zero only when req is zero.
REQ-011 ARB_FIX: SHALL grant the lowest-index requesting port.
REQ-012 ARB_RR: SHALL grant the first requesting port at or above pointer ptr, wrapping PN-1 -> 0.
REQ-013 On handshake (m.vld & m.rdy) with granted index g, ptr SHALL load (g+1) mod PN; otherwise ptr SHALL hold.
REQ-014 Lock: while m.vld & ~m.rdy, SHALL register the granted index, and SHALL hold the grant in following cycles until the handshake, regardless of other requests.
REQ-015 SHALL drive m.vld = |req (combinational, no request-phase latency).
REQ-016 SHALL drive m.wen/ben/adr/wdt from the granted port; when no grant, values are don't-care.
REQ-017 SHALL drive s[i].rdy = gnt[i] & m.rdy; non-granted ports SHALL see rdy=0.
REQ-018 On handshake, rsp_sel SHALL register g; response phase is exactly 1 cycle after the handshake.
REQ-019 SHALL broadcast m.rdt to every s[i].rdt; s[i].err SHALL equal m.err when i==rsp_sel, else 0.
REQ-020 Back-to-back handshakes from different ports SHALL be supported every cycle, with no bubble.
REQ-021 Simultaneous request from all ports in ARB_RR SHALL yield grants in strict rotation order.
REQ-022 A requester dropping vld without handshake SHALL NOT occur (protocol violation); behaviour undefined.
REQ-023 PN=1: select width SHALL be max(1,$clog2(PN)); the port SHALL pass through and ptr SHALL stay 0.
REQ-024 Non-power-of-two PN: ptr SHALL never hold a value >= PN.

Reset
REQ-025 While rst=0, ptr, rsp_sel and the lock flag SHALL all be 0 and m.vld SHALL be 0.
REQ-026 Reset asserted mid-transfer SHALL discard the lock and any pending response routing.
REQ-027 The first grant after reset release SHALL follow REQ-011/012, with ptr=0.

Structure
REQ-028 Arbitration-mode enum (ARB_FIX, ARB_RR) SHALL live in shared package tcb_pkg.
REQ-029 Priority search SHALL be a sub-module tcb_arb_rr (req, ptr -> one-hot gnt, index), purely combinational, reused by ARB_FIX with ptr=0.
REQ-030 Per-port interface signals SHALL be gathered into indexable arrays via generate loops, because interface arrays are not dynamically indexable.

Verification
REQ-031 PN=4, RR, all four vld=1, m.rdy=1 for 8 cycles -> grants 0,1,2,3,0,1,2,3; ptr ends 0.
REQ-032 PN=4, FIX, ports 1 and 3 requesting, m.rdy=1 -> port 1 granted until it drops vld, then port 3.
REQ-033 PN=2, RR, port 1 requests, m.rdy=0 for 3 cycles; port 0 requests in cycle 2 -> grant stays 1 until the handshake, then port 0 granted.
REQ-034 PN=3, handshake port 2 adr=0x100 wen=0, next cycle m.rdt=0xDEADBEEF m.err=1 -> all s[].rdt=0xDEADBEEF, only s[2].err=1.
REQ-035 PN=3, RR, ptr=2, port 2 handshakes -> ptr wraps to 0; a following request on port 0 alone is granted.
REQ-036 rst pulled low while port 1 is stalled (m.rdy=0) -> m.vld=0, ptr=0, rsp_sel=0 immediately; after release with port 0 requesting, port 0 is granted.

Source files
------------

// File: rtl/tcb_pkg.sv
// Shared definitions for the TCB arbiter: arbitration modes, lock states and select-width helper.
package tcb_pkg;

  typedef enum logic {
    ARB_FIX = 1'b0,
    ARB_RR  = 1'b1
  } arb_mode_e;

  typedef enum logic {
    LK_IDLE = 1'b0,
    LK_HELD = 1'b1
  } lock_st_e;

  // Index width for PN ports; a single port still needs one bit.
  function automatic int unsigned sel_w(input int unsigned pn);
    return (pn > 1) ? $clog2(pn) : 1;
  endfunction

endpackage

// File: rtl/tcb_if.sv
// TCB point-to-point bus: request phase (vld/rdy handshake) plus one-cycle-later response.
interface tcb_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  localparam int unsigned BW = DW / 8;

  logic          vld;
  logic          wen;
  logic [BW-1:0] ben;
  logic [AW-1:0] adr;
  logic [DW-1:0] wdt;
  logic          rdy;
  logic [DW-1:0] rdt;
  logic          err;

  modport man (output vld, wen, ben, adr, wdt, input  rdy, rdt, err);
  modport sub (input  vld, wen, ben, adr, wdt, output rdy, rdt, err);

endinterface

// File: rtl/tcb_arb_rr.sv
// Combinational priority search: first requester at or above ptr, wrapping; ptr=0 gives fixed priority.
module tcb_arb_rr
  import tcb_pkg::*;
#(
  parameter  int unsigned PN = 2,
  localparam int unsigned SW = sel_w(PN)
) (
  input  logic [PN-1:0] req,
  input  logic [SW-1:0] ptr,
  output logic [PN-1:0] gnt,
  output logic [SW-1:0] idx
);

  logic [PN-1:0] rot;
  logic [SW:0]   sum;
  logic          found;

  // Rotate requests so bit 0 is the port at ptr, take the first set bit, map back.
  always_comb begin
    rot   = PN'({req, req} >> ptr);
    gnt   = '0;
    idx   = '0;
    sum   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < PN; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = (SW+1)'(ptr) + (SW+1)'(k);
        if (sum >= (SW+1)'(PN)) sum = sum - (SW+1)'(PN);
      end
    end
    if (found) begin
      idx = SW'(sum);
      gnt = PN'(1) << idx;
    end
  end

endmodule

// File: rtl/tcb_arb.sv
// PN-to-1 TCB arbiter with fixed or round-robin priority, grant lock on stall and response routing.
module tcb_arb
  import tcb_pkg::*;
#(
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 32,
  parameter int unsigned PN   = 2,
  parameter arb_mode_e   MODE = ARB_RR
) (
  input  logic clk,
  input  logic rst,
  tcb_if.sub   s [PN-1:0],
  tcb_if.man   m
);

  localparam int unsigned SW = sel_w(PN);
  localparam int unsigned BW = DW / 8;

  logic [PN-1:0] req;
  logic          wen_a [PN];
  logic [BW-1:0] ben_a [PN];
  logic [AW-1:0] adr_a [PN];
  logic [DW-1:0] wdt_a [PN];

  lock_st_e      state, state_nxt;
  logic [SW-1:0] ptr, ptr_nxt;
  logic [SW-1:0] rsp_sel, rsp_nxt;
  logic [SW-1:0] lock_idx, lock_nxt;
  logic [SW-1:0] arb_ptr, arb_idx, idx;
  logic [PN-1:0] arb_gnt, gnt;
  logic          vld, hs;

  // Interface arrays cannot be indexed at run time, so flatten them here.
  for (genvar i = 0; i < PN; i++) begin : g_port
    assign req[i]   = s[i].vld;
    assign wen_a[i] = s[i].wen;
    assign ben_a[i] = s[i].ben;
    assign adr_a[i] = s[i].adr;
    assign wdt_a[i] = s[i].wdt;
    assign s[i].rdy = gnt[i] & m.rdy;
    assign s[i].rdt = m.rdt;
    assign s[i].err = m.err & (rsp_sel == SW'(i));
  end

  assign arb_ptr = (MODE == ARB_RR) ? ptr : '0;

  tcb_arb_rr #(.PN(PN)) u_rr (
    .req (req),
    .ptr (arb_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= LK_IDLE;
      ptr      <= '0;
      rsp_sel  <= '0;
      lock_idx <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      rsp_sel  <= rsp_nxt;
      lock_idx <= lock_nxt;
    end
  end

  // A stalled request keeps its grant until it completes, whatever else arrives.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    rsp_nxt   = rsp_sel;
    lock_nxt  = lock_idx;
    idx       = (state == LK_HELD) ? lock_idx : arb_idx;
    gnt       = (state == LK_HELD) ? PN'(1) << lock_idx : arb_gnt;
    if (!rst) gnt = '0;
    vld       = rst & (|req);
    hs        = vld & m.rdy;

    case (state)
      LK_IDLE: if (vld && !m.rdy) begin
        state_nxt = LK_HELD;
        lock_nxt  = idx;
      end
      LK_HELD: if (hs) state_nxt = LK_IDLE;
      default: state_nxt = LK_IDLE;
    endcase

    if (hs) begin
      rsp_nxt = idx;
      ptr_nxt = (idx == SW'(PN-1)) ? '0 : idx + 1'b1;
    end

    m.vld = vld;
    m.wen = 1'b0;
    m.ben = '0;
    m.adr = '0;
    m.wdt = '0;
    for (int unsigned k = 0; k < PN; k++) begin
      if (gnt[k]) begin
        m.wen = wen_a[k];
        m.ben = ben_a[k];
        m.adr = adr_a[k];
        m.wdt = wdt_a[k];
      end
    end
  end

endmodule
